// File: rtl/qspi_target_mem.sv
// qspi_target_mem: QSPI-SRAM target (memory emulator side).
//
// Decodes the 0x35 / 0xEB / 0x38 command set arriving on the QSPI pads.
// Presents the accesses on a word-wide request/acknowledge memory port.
// Lets an on-chip buffer stand in for external QSPI SRAM.
// Everything runs on clk. The pad inputs are oversampled, so f_clk >= 6*f_sck.
//
// Build option:
//   QSPI_TARGET_EXIT_QUAD_EN - quad command 0xF5 leaves quad mode at the
//                              following ncs rise. When it is not defined,
//                              quad mode is sticky until reset.
//
// Parameters:
//   ASZ  word-address width; uses the low ASZ bits of the 24-bit address (ASZ <= 24)
//   DSZ  data word width, a multiple of 4 and at least 8
//   WAIT dummy SCK cycles for 0xEB between the address and the first read nibble
//
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   qspi_sck/ncs/data_in  raw pad inputs from the master
//   qspi_data_out(_en)    read nibble and pad output enable
//   mem_addr/wdata/we     word address, write data, one-clk write strobe
//   mem_rd_req/ack/rdata  read request held until ack; data valid with ack
//   quad_mode             quad protocol active
//   rd_underrun           sticky; a read word was due before its data arrived
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | chip deselected, waiting for ncs fall
// S_CMD    | shifting the command (8 bits on IO0, or 2 nibbles in quad)
// S_ADDR   | shifting the 24-bit address, 6 nibbles
// S_WAIT   | 0xEB dummy cycles; first word is being fetched
// S_RDATA  | driving read nibbles on SCK falling edges
// S_WDATA  | collecting write nibbles into words
// S_IGNORE | unsupported or finished command; idle until ncs rises
module qspi_target_mem #(
  parameter int ASZ  = 22,
  parameter int DSZ  = 16,
  parameter int WAIT = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           qspi_sck,
  input  logic           qspi_ncs,
  input  logic [3:0]     qspi_data_in,
  output logic [3:0]     qspi_data_out,
  output logic           qspi_data_out_en,
  output logic [ASZ-1:0] mem_addr,
  output logic [DSZ-1:0] mem_wdata,
  output logic           mem_we,
  output logic           mem_rd_req,
  input  logic           mem_rd_ack,
  input  logic [DSZ-1:0] mem_rdata,
  output logic           quad_mode,
  output logic           rd_underrun
);

  localparam int NIB = DSZ / 4;
  localparam int NW  = $clog2(NIB + 1);
  localparam logic [NW-1:0] NIB_C    = NW'(NIB);
  localparam logic [NW-1:0] NIB_LAST = NW'(NIB - 1);
  localparam logic [7:0]    WAIT_C   = 8'(WAIT);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_IGNORE
  } state_t;

  // Pad synchronisers. The edge events come from stages 2 and 3, and the data
  // word is taken from stage 2, so it lines up with the detected sck edge.
  logic [2:0] sck_q, ncs_q;
  logic [3:0] din1_q, din2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_q  <= 3'b000;
      ncs_q  <= 3'b111;
      din1_q <= 4'h0;
      din2_q <= 4'h0;
    end else begin
      sck_q  <= {sck_q[1:0], qspi_sck};
      ncs_q  <= {ncs_q[1:0], qspi_ncs};
      din1_q <= qspi_data_in;
      din2_q <= din1_q;
    end
  end

  logic sck_rise, sck_fall, ncs_rise, ncs_fall;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ncs_rise = ncs_q[1] & ~ncs_q[2];
  assign ncs_fall = ~ncs_q[1] & ncs_q[2];

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     sr_q, sr_d;
  logic [19:0]    asr_q, asr_d;
  logic           is_rd_q, is_rd_d;
  logic           quad_q, quad_d;
  logic           quad_pend_q, quad_pend_d;
  logic           exit_pend_q, exit_pend_d;
  logic [ASZ-1:0] addr_q, addr_d;
  logic [DSZ-1:0] wdata_q, wdata_d;
  logic           we_q, we_d;
  logic [DSZ-1:0] wsh_q, wsh_d;
  logic [NW-1:0]  wcnt_q, wcnt_d;
  logic           req_q, req_d;
  logic           discard_q, discard_d;
  logic [DSZ-1:0] pf_q, pf_d;
  logic           pf_vld_q, pf_vld_d;
  logic [DSZ-1:0] sh_q, sh_d;
  logic [NW-1:0]  nib_q, nib_d;
  logic [3:0]     dout_q, dout_d;
  logic           oe_q, oe_d;
  logic           under_q, under_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      asr_q       <= '0;
      is_rd_q     <= 1'b0;
      quad_q      <= 1'b0;
      quad_pend_q <= 1'b0;
      exit_pend_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wsh_q       <= '0;
      wcnt_q      <= '0;
      req_q       <= 1'b0;
      discard_q   <= 1'b0;
      pf_q        <= '0;
      pf_vld_q    <= 1'b0;
      sh_q        <= '0;
      nib_q       <= '0;
      dout_q      <= 4'h0;
      oe_q        <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      asr_q       <= asr_d;
      is_rd_q     <= is_rd_d;
      quad_q      <= quad_d;
      quad_pend_q <= quad_pend_d;
      exit_pend_q <= exit_pend_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      wsh_q       <= wsh_d;
      wcnt_q      <= wcnt_d;
      req_q       <= req_d;
      discard_q   <= discard_d;
      pf_q        <= pf_d;
      pf_vld_q    <= pf_vld_d;
      sh_q        <= sh_d;
      nib_q       <= nib_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      under_q     <= under_d;
    end
  end

  logic [7:0]     cmd_spi, cmd_quad;
  logic [ASZ-1:0] addr_full;
  logic [DSZ-1:0] wsh_next;
  logic [DSZ-1:0] load_word;

  assign cmd_spi   = {sr_q[6:0], din2_q[0]};
  assign cmd_quad  = {sr_q[3:0], din2_q};
  assign addr_full = ASZ'({asr_q, din2_q});
  assign wsh_next  = (wsh_q << 4) | {{(DSZ-4){1'b0}}, din2_q};
  // If the prefetch is empty when a word is due, that word goes out as zeros.
  assign load_word = pf_vld_q ? pf_q : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    asr_d       = asr_q;
    is_rd_d     = is_rd_q;
    quad_d      = quad_q;
    quad_pend_d = quad_pend_q;
    exit_pend_d = exit_pend_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    wsh_d       = wsh_q;
    wcnt_d      = wcnt_q;
    req_d       = req_q;
    discard_d   = discard_q;
    pf_d        = pf_q;
    pf_vld_d    = pf_vld_q;
    sh_d        = sh_q;
    nib_d       = nib_q;
    dout_d      = dout_q;
    oe_d        = oe_q;
    under_d     = under_q;

    // Post-increment after a write strobe, so mem_addr holds the written word's address during mem_we.
    if (we_q) addr_d = addr_q + 1'b1;

    // An ack for a request that was still open at ncs rise only closes that request. Its data is dropped.
    if (req_q && mem_rd_ack) begin
      req_d     = 1'b0;
      discard_d = 1'b0;
      if (!discard_q) begin
        pf_d     = mem_rdata;
        pf_vld_d = 1'b1;
      end
    end

    if (ncs_rise) begin
      state_d     = S_IDLE;
      oe_d        = 1'b0;
      pf_vld_d    = 1'b0;
      discard_d   = req_d;
      if (quad_pend_q) quad_d = 1'b1;
`ifdef QSPI_TARGET_EXIT_QUAD_EN
      if (exit_pend_q) quad_d = 1'b0;
`endif
      quad_pend_d = 1'b0;
      exit_pend_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ncs_fall) begin
            state_d = S_CMD;
            cnt_d   = '0;
            sr_d    = '0;
          end
        end

        S_CMD: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 8'd1;
            if (quad_q) begin
              sr_d = cmd_quad;
              if (cnt_q == 8'd1) begin
                cnt_d = '0;
                asr_d = '0;
                case (cmd_quad)
                  8'hEB: begin state_d = S_ADDR; is_rd_d = 1'b1; end
                  8'h38: begin state_d = S_ADDR; is_rd_d = 1'b0; end
`ifdef QSPI_TARGET_EXIT_QUAD_EN
                  8'hF5: begin state_d = S_IGNORE; exit_pend_d = 1'b1; end
`endif
                  default: state_d = S_IGNORE;
                endcase
              end
            end else begin
              sr_d = cmd_spi;
              if (cnt_q == 8'd7) begin
                cnt_d   = '0;
                state_d = S_IGNORE;
                if (cmd_spi == 8'h35) quad_pend_d = 1'b1;
              end
            end
          end
        end

        S_ADDR: begin
          if (sck_rise) begin
            asr_d = {asr_q[15:0], din2_q};
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd5) begin
              cnt_d  = '0;
              addr_d = addr_full;
              if (is_rd_q) begin
                state_d   = S_WAIT;
                req_d     = 1'b1;
                discard_d = 1'b0;
                pf_vld_d  = 1'b0;
              end else begin
                state_d = S_WDATA;
                wcnt_d  = '0;
              end
            end
          end
        end

        S_WAIT: begin
          if (sck_rise && cnt_q != WAIT_C) cnt_d = cnt_q + 8'd1;
          if (sck_fall && cnt_q == WAIT_C) begin
            state_d  = S_RDATA;
            oe_d     = 1'b1;
            dout_d   = load_word[DSZ-1 -: 4];
            sh_d     = load_word << 4;
            nib_d    = NW'(1);
            pf_vld_d = 1'b0;
            addr_d   = addr_q + 1'b1;
            req_d    = 1'b1;
            if (!pf_vld_q) under_d = 1'b1;
          end
        end

        S_RDATA: begin
          if (sck_fall) begin
            if (nib_q == NIB_C) begin
              dout_d   = load_word[DSZ-1 -: 4];
              sh_d     = load_word << 4;
              nib_d    = NW'(1);
              pf_vld_d = 1'b0;
              addr_d   = addr_q + 1'b1;
              req_d    = 1'b1;
              if (!pf_vld_q) under_d = 1'b1;
            end else begin
              dout_d = sh_q[DSZ-1 -: 4];
              sh_d   = sh_q << 4;
              nib_d  = nib_q + 1'b1;
            end
          end
        end

        S_WDATA: begin
          if (sck_rise) begin
            wsh_d = wsh_next;
            if (wcnt_q == NIB_LAST) begin
              wdata_d = wsh_next;
              we_d    = 1'b1;
              wcnt_d  = '0;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end

        S_IGNORE: ;

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign qspi_data_out    = dout_q;
  assign qspi_data_out_en = oe_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign mem_we           = we_q;
  assign mem_rd_req       = req_q;
  assign quad_mode        = quad_q;
  assign rd_underrun      = under_q;

endmodule
